// File: rtl/fp_maf.sv
// fp_maf: fused multiply-add, result = round_rne(A*B + C); binary32 operands, binary64 result, latency 2.
// Optional macro MAF_FLAGS_EN adds flags[1:0] = {invalid, inexact}, valid alongside out_valid.
module fp_maf (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] C,
  output logic        out_valid,
`ifdef MAF_FLAGS_EN
  output logic [1:0]  flags,
`endif
  output logic [63:0] result
);

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  // exp is the unbiased exponent of mant[23]; subnormals arrive normalised
  typedef struct packed {
    logic               sign;
    logic               zero;
    logic               inf;
    logic               nan;
    logic signed [11:0] exp;
    logic [23:0]        mant;
  } unp_t;

  typedef struct packed {
    logic               vld;
    logic               qnan;
    logic               inf;
    logic               inf_sign;
    logic               pz;
    logic               cz;
    logic               sp;
    logic               sc;
    logic signed [11:0] ep;
    logic [47:0]        mp;
    logic signed [11:0] ec;
    logic [23:0]        mc;
  } s1_t;

  function automatic unp_t unpack(input logic [31:0] x);
    unp_t       u;
    logic [4:0] n;
    u.sign = x[31];
    u.zero = (x[30:23] == 8'd0) && (x[22:0] == 23'd0);
    u.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    u.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    n      = 5'd0;
    if (x[30:23] == 8'd0) begin
      for (int i = 0; i < 23; i++) begin
        if (x[i]) n = 5'(23 - i);
      end
      u.mant = {1'b0, x[22:0]} << n;
      u.exp  = -12'sd126 - $signed({7'd0, n});
    end else begin
      u.mant = {1'b1, x[22:0]};
      u.exp  = $signed({4'd0, x[30:23]}) - 12'sd127;
    end
    return u;
  endfunction

  unp_t               ua, ub, uc;
  logic [47:0]        prod;
  logic signed [11:0] esum;
  logic               p_inf;
  s1_t                s1_d, s1_q;

  always_comb begin
    ua    = unpack(A);
    ub    = unpack(B);
    uc    = unpack(C);
    prod  = {24'd0, ua.mant} * {24'd0, ub.mant};
    esum  = ua.exp + ub.exp;
    p_inf = ua.inf | ub.inf;

    s1_d          = '0;
    s1_d.vld      = in_valid;
    s1_d.sp       = ua.sign ^ ub.sign;
    s1_d.sc       = uc.sign;
    s1_d.pz       = ua.zero | ub.zero;
    s1_d.cz       = uc.zero;
    s1_d.qnan     = ua.nan | ub.nan | uc.nan
                  | (ua.inf & ub.zero) | (ua.zero & ub.inf)
                  | (p_inf & uc.inf & (s1_d.sp != uc.sign));
    s1_d.inf      = p_inf | uc.inf;
    s1_d.inf_sign = p_inf ? s1_d.sp : uc.sign;
    // keep the product MSB at bit 47 so ep is always the exponent of the leading one
    if (prod[47]) begin
      s1_d.mp = prod;
      s1_d.ep = esum + 12'sd1;
    end else begin
      s1_d.mp = {prod[46:0], 1'b0};
      s1_d.ep = esum;
    end
    s1_d.ec = uc.exp;
    s1_d.mc = uc.mant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_q <= '0;
    else     s1_q <= s1_d;
  end

  logic               p_big, big_sign, eff_sub, neg, far, up, ovf, res_sign;
  logic signed [12:0] sep, sec, e_big, d, e_res;
  logic [127:0]       pw, cw, big_w, small_w, aligned, mag, norm;
  logic [255:0]       sh;
  logic [128:0]       diff;
  logic [6:0]         lz;
  logic [53:0]        rounded;
  logic [51:0]        frac;
  logic [63:0]        res_pack, res_val;
  logic [63:0]        result_d, result_q;
  logic               out_valid_d, out_valid_q;

  always_comb begin
    sep = {s1_q.ep[11], s1_q.ep};
    sec = {s1_q.ec[11], s1_q.ec};
    // window: larger-exponent operand's leading one sits at bit 125, two bits of carry headroom
    pw  = {2'b00, s1_q.mp, 78'd0};
    cw  = {2'b00, s1_q.mc, 102'd0};

    p_big    = s1_q.cz | (!s1_q.pz && (sep >= sec));
    big_w    = p_big ? pw : cw;
    small_w  = p_big ? cw : pw;
    e_big    = p_big ? sep : sec;
    big_sign = p_big ? s1_q.sp : s1_q.sc;
    d        = p_big ? (sep - sec) : (sec - sep);
    far      = (d > 13'sd127) || (d < 13'sd0);

    // bits shifted below the window collapse into a jammed sticky at bit 0
    sh = {small_w, 128'd0} >> d[6:0];
    if (far) aligned = {127'd0, |small_w};
    else     aligned = sh[255:128] | {127'd0, |sh[127:0]};

    eff_sub  = s1_q.sp ^ s1_q.sc;
    diff     = eff_sub ? ({1'b0, big_w} - {1'b0, aligned})
                       : ({1'b0, big_w} + {1'b0, aligned});
    neg      = diff[128];
    mag      = neg ? (~diff[127:0] + 128'd1) : diff[127:0];
    res_sign = neg ? ~big_sign : big_sign;

    lz = 7'd0;
    for (int i = 0; i < 128; i++) begin
      if (mag[i]) lz = 7'(127 - i);
    end
    norm = mag << lz;

    up       = norm[74] & ((|norm[73:0]) | norm[75]);
    rounded  = {1'b0, norm[127:75]} + {53'd0, up};
    ovf      = rounded[53];
    frac     = ovf ? rounded[52:1] : rounded[51:0];
    e_res    = e_big + 13'sd2 - $signed({6'd0, lz}) + $signed({12'd0, ovf});
    res_pack = {res_sign, 11'(e_res + 13'sd1023), frac};

    if (s1_q.qnan)                 res_val = QNAN;
    else if (s1_q.inf)             res_val = {s1_q.inf_sign, 11'h7FF, 52'd0};
    else if (s1_q.pz && s1_q.cz)   res_val = {s1_q.sp & s1_q.sc, 63'd0};
    else if (mag == 128'd0)        res_val = 64'd0;
    else                           res_val = res_pack;

    out_valid_d = s1_q.vld;
    result_d    = s1_q.vld ? res_val : result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= 64'd0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;

`ifdef MAF_FLAGS_EN
  logic [1:0] flags_d, flags_q;

  always_comb begin
    flags_d = flags_q;
    if (s1_q.vld) begin
      flags_d[1] = s1_q.qnan;
      flags_d[0] = !s1_q.qnan && !s1_q.inf && !(s1_q.pz && s1_q.cz)
                 && (norm[74] || (|norm[73:0]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= 2'b00;
    else     flags_q <= flags_d;
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_maf.sv
// Bench for fp_maf: directed vectors with literal results, a real-arithmetic reference model,
// and a per-cycle compare of out_valid/result (and flags when MAF_FLAGS_EN is defined).
module tb_fp_maf;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] A, B, C;
  logic        out_valid;
  logic [63:0] result;
`ifdef MAF_FLAGS_EN
  logic [1:0]  flags;
`endif

  fp_maf dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .C         (C),
    .out_valid (out_valid),
`ifdef MAF_FLAGS_EN
    .flags     (flags),
`endif
    .result    (result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic        run;
  logic        drv_has_lit;
  logic [63:0] drv_lit;
  logic [2:0]  drv_lfl;

  typedef struct packed {
    logic        vld;
    logic [63:0] res;
    logic [1:0]  fl;
    logic        has_lit;
    logic [63:0] lit;
    logic [2:0]  lfl;
  } ent_t;

  ent_t p1, p2;

  function automatic real f2r(input logic [31:0] x);
    real m;
    if (x[30:23] == 8'd0) m = real'(x[22:0]) * $pow(2.0, -149.0);
    else                  m = real'({1'b1, x[22:0]}) * $pow(2.0, real'(int'(x[30:23]) - 150));
    return x[31] ? -m : m;
  endfunction

  // returns {flags, result}; product of two binary32 values is exact in a double,
  // so one double addition gives the single correctly rounded sum
  function automatic logic [65:0] model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic an, bn, cn, ai, bi, ci, az, bz, cz, pz, pi, ps;
    logic [63:0] r;
    logic [1:0]  fl;
    real p, cr, s, bb, err;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    cn = (c[30:23] == 8'hFF) && (c[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    ci = (c[30:23] == 8'hFF) && (c[22:0] == 0);
    az = (a[30:0] == 0);
    bz = (b[30:0] == 0);
    cz = (c[30:0] == 0);
    pz = az | bz;
    pi = ai | bi;
    ps = a[31] ^ b[31];
    fl = 2'b00;
    if (an || bn || cn || (ai && bz) || (az && bi) || (pi && ci && (ps != c[31]))) begin
      r  = QNAN;
      fl = 2'b10;
    end else if (pi) begin
      r = {ps, 11'h7FF, 52'd0};
    end else if (ci) begin
      r = {c[31], 11'h7FF, 52'd0};
    end else begin
      p  = f2r(a) * f2r(b);
      cr = f2r(c);
      s  = p + cr;
      bb = s - p;
      err = (p - (s - bb)) + (cr - bb);
      if (s == 0.0) r = (pz && cz && ps && c[31]) ? 64'h8000_0000_0000_0000 : 64'd0;
      else          r = $realtobits(s);
      fl[0] = (err != 0.0);
    end
    return {fl, r};
  endfunction

  function automatic ent_t mk_entry(input logic v, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] c, input logic hl, input logic [63:0] lit,
                                    input logic [2:0] lfl);
    ent_t        e;
    logic [65:0] m;
    e = '0;
    if (v) begin
      m         = model(a, b, c);
      e.vld     = 1'b1;
      e.res     = m[63:0];
      e.fl      = m[65:64];
      e.has_lit = hl;
      e.lit     = lit;
      e.lfl     = lfl;
    end
    return e;
  endfunction

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= mk_entry(in_valid, A, B, C, drv_has_lit, drv_lit, drv_lfl);
      if (p1.vld) p2 <= p1;
      else        p2.vld <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (run && !rst) begin
      check64("out_valid", {63'd0, out_valid}, {63'd0, p2.vld});
      check64("result", result, p2.res);
      if (p2.vld && p2.has_lit) check64("result_literal", result, p2.lit);
`ifdef MAF_FLAGS_EN
      if (p2.vld) check64("flags", {62'd0, flags}, {62'd0, p2.fl});
      if (p2.vld && p2.lfl[2]) check64("flags_literal", {62'd0, flags}, {62'd0, p2.lfl[1:0]});
`endif
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic hl, input logic [63:0] lit, input logic [2:0] lfl);
    @(negedge clk);
    in_valid    = 1'b1;
    A           = a;
    B           = b;
    C           = c;
    drv_has_lit = hl;
    drv_lit     = lit;
    drv_lfl     = lfl;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid    = 1'b0;
    A           = $urandom;
    B           = $urandom;
    C           = $urandom;
    drv_has_lit = 1'b0;
    drv_lfl     = 3'b000;
  endtask

  task automatic spec_vectors();
    send(32'h40000000, 32'h3F800000, 32'h40400000, 1'b1, 64'h4014_0000_0000_0000, 3'b100);
    send(32'h41200000, 32'h40A00000, 32'h41000000, 1'b1, 64'h404D_0000_0000_0000, 3'b100);
    send(32'h43000000, 32'h42800000, 32'h42800000, 1'b1, 64'h40C0_2000_0000_0000, 3'b100);
    send(32'hC0A00000, 32'h40000000, 32'h41200000, 1'b1, 64'h0000_0000_0000_0000, 3'b100);
    send(32'hC1800000, 32'hC1000000, 32'h00000000, 1'b1, 64'h4060_0000_0000_0000, 3'b100);
    send(32'h7F800000, 32'h00000000, 32'h3F800000, 1'b1, QNAN,                    3'b110);
  endtask

  logic [31:0] ra, rb, rc;
  int          e;

  initial begin
    rst = 1'b1; run = 1'b0; in_valid = 1'b0;
    A = '0; B = '0; C = '0;
    drv_has_lit = 1'b0; drv_lit = '0; drv_lfl = '0;
    #1;
    check64("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check64("reset_result", result, 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0; run = 1'b1;

    spec_vectors();
    idle(); idle();
    // exact product with carries, ties both ways, far addend, subnormals, signed zeros, infinities
    send(32'h3F800001, 32'h3F800001, 32'h00000000, 1'b1, 64'h3FF0_0000_4000_0040, 3'b100);
    send(32'h2A000000, 32'h3A800000, 32'h3F800000, 1'b1, 64'h3FF0_0000_0000_0000, 3'b101);
    send(32'h40400000, 32'h25000000, 32'h3F800000, 1'b1, 64'h3FF0_0000_0000_0002, 3'b101);
    send(32'h00000001, 32'h00000001, 32'h7F000000, 1'b1, 64'h47E0_0000_0000_0000, 3'b101);
    send(32'h00000001, 32'h3F800000, 32'h00000000, 1'b1, 64'h36A0_0000_0000_0000, 3'b100);
    send(32'h80000000, 32'h3F800000, 32'h80000000, 1'b1, 64'h8000_0000_0000_0000, 3'b100);
    send(32'h00000000, 32'h3F800000, 32'h80000000, 1'b1, 64'h0000_0000_0000_0000, 3'b100);
    send(32'h7F800000, 32'h3F800000, 32'hFF800000, 1'b1, QNAN,                    3'b110);
    send(32'hFF800000, 32'h40000000, 32'h3F800000, 1'b1, 64'hFFF0_0000_0000_0000, 3'b100);
    send(32'h3F800000, 32'h3F800000, 32'h7FC00001, 1'b1, QNAN,                    3'b110);
    send(32'h3F800001, 32'h3F800001, 32'hBF800000, 1'b1, 64'h3E90_0000_1000_0000, 3'b100);
    idle();

    // bubbles between issues: result must hold its last value
    spec_vectors();
    idle(); idle(); idle();

    // asynchronous reset mid-stream with in_valid held high
    send(32'h41200000, 32'h40A00000, 32'h41000000, 1'b1, 64'h404D_0000_0000_0000, 3'b100);
    send(32'h40000000, 32'h3F800000, 32'h40400000, 1'b1, 64'h4014_0000_0000_0000, 3'b100);
    #2 rst = 1'b1;
    #1;
    check64("rst_async_out_valid", {63'd0, out_valid}, 64'd0);
    check64("rst_async_result", result, 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check64("post_rst_cycle1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check64("post_rst_cycle2_valid", {63'd0, out_valid}, 64'd1);
    check64("post_rst_cycle2_result", result, 64'h4014_0000_0000_0000);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(4) == 0) begin
        idle();
      end else begin
        ra = $urandom; rb = $urandom; rc = $urandom;
        case ($urandom_range(3))
          1: begin
            e = int'(ra[30:23]) + int'(rb[30:23]) - 127 + int'($urandom_range(4)) - 2;
            if (e >= 1 && e <= 254) rc[30:23] = e[7:0];
            rc[31] = ~(ra[31] ^ rb[31]);
          end
          2: begin
            ra[30:23] = 8'h00;
            rc[30:23] = 8'($urandom_range(100, 140));
          end
          3: begin
            ra[11:0] = 12'd0; rb[11:0] = 12'd0;
            ra[30:23] = 8'($urandom_range(110, 140));
            rb[30:23] = 8'($urandom_range(110, 140));
            rc = {~(ra[31] ^ rb[31]), 8'(int'(ra[30:23]) + int'(rb[30:23]) - 127), rc[22:0]};
          end
          default: ;
        endcase
        send(ra, rb, rc, 1'b0, 64'd0, 3'b000);
      end
    end
    idle(); idle(); idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
